// File: rtl/crc_serial_if.sv
// Serial CRC bus: framed message bits and polynomial in, remainder and check flag out.
interface crc_serial_if #(
    parameter int unsigned CRC_WIDTH = 4
) ();
    logic                 ctrl_en;
    logic                 data_in;
    logic [CRC_WIDTH-1:0] poly;
    logic                 chk_en;
    logic [CRC_WIDTH-1:0] crc_seq;
    logic                 crc_error;

    modport master (
        output ctrl_en,
        output data_in,
        output poly,
        output chk_en,
        input  crc_seq,
        input  crc_error
    );

    modport slave (
        input  ctrl_en,
        input  data_in,
        input  poly,
        input  chk_en,
        output crc_seq,
        output crc_error
    );
endinterface

// File: rtl/crc_serial.sv
// Bit-serial CRC generator/checker, MSB first, augmented (division) form.
// Frames are delimited by ctrl_en; end of frame optionally latches a non-zero-remainder flag.
module crc_serial #(
    parameter int unsigned CRC_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    crc_serial_if.slave  bus
);
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic                 en_q, en_d;
    logic                 err_q, err_d;
    logic [CRC_WIDTH-1:0] base;
    logic [CRC_WIDTH-1:0] shifted;
    logic                 frame_start;
    logic                 frame_end;

    always_comb begin
        frame_start = bus.ctrl_en && !en_q;
        frame_end   = !bus.ctrl_en && en_q;
        // A frame start divides from a zero remainder rather than the stale one.
        base        = frame_start ? '0 : crc_q;
        shifted     = {base[CRC_WIDTH-2:0], bus.data_in}
                      ^ (base[CRC_WIDTH-1] ? bus.poly : '0);

        crc_d = crc_q;
        err_d = err_q;
        en_d  = bus.ctrl_en;

        if (bus.ctrl_en) begin
            crc_d = shifted;
            if (frame_start) begin
                err_d = 1'b0;
            end
        end else if (frame_end && bus.chk_en) begin
            err_d = |crc_q;
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            crc_q <= '0;
            en_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            en_q  <= en_d;
            err_q <= err_d;
        end
    end

    assign bus.crc_seq   = crc_q;
    assign bus.crc_error = err_q;
endmodule

// File: tb/tb_crc_serial.sv
// Scoreboarded bench for crc_serial: directed frames with hand-computed remainders.
module tb_crc_serial;
    localparam int unsigned W = 4;

    typedef struct {
        string        name;
        logic [W-1:0] crc;
        logic         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    crc_serial_if #(.CRC_WIDTH(W)) bus ();

    crc_serial #(.CRC_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drains expected entries at the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (bus.crc_seq !== e.crc) begin
                fails++;
                $display("FAIL %s crc_seq: got %b, expected %b", e.name, bus.crc_seq, e.crc);
            end
            tests++;
            if (bus.crc_error !== e.err) begin
                fails++;
                $display("FAIL %s crc_error: got %b, expected %b", e.name, bus.crc_error, e.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [W-1:0] crc, input logic err);
        exp_t e;
        e.name = name;
        e.crc  = crc;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.ctrl_en = 1'b1;
            bus.data_in = bits[i];
            tick();
        end
        bus.ctrl_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        bus.ctrl_en = 1'b0;
        bus.data_in = 1'b0;
        bus.poly    = 4'b0011;
        bus.chk_en  = 1'b0;

        tick(); tick(); tick();
        expect_now("reset", 4'b0000, 1'b0);
        rst_n = 1'b0;
        tick();

        // Generate mode: message 1010_0110 plus four zeros.
        send_frame(16'b1010_0110_0000, 12);
        expect_now("gen1", 4'b1110, 1'b0);
        tick();
        expect_now("gen1_hold", 4'b1110, 1'b0);
        tick();

        send_frame(16'b1010_0010_0000, 12);
        expect_now("gen2", 4'b0010, 1'b0);
        tick();
        expect_now("gen2_err", 4'b0010, 1'b0);

        // Check mode: intact frame then corrupted last bit.
        bus.chk_en = 1'b1;
        tick();
        send_frame(16'b1010_0110_1110, 12);
        expect_now("chk_ok", 4'b0000, 1'b0);
        tick();
        expect_now("chk_ok_err", 4'b0000, 1'b0);
        tick();
        send_frame(16'b1010_0110_1111, 12);
        expect_now("chk_bad", 4'b0001, 1'b0);
        tick();
        expect_now("chk_bad_err", 4'b0001, 1'b1);
        tick();

        bus.chk_en  = 1'b0;
        bus.ctrl_en = 1'b1;
        bus.data_in = 1'b1;
        tick();
        expect_now("start_clears_err", 4'b0001, 1'b0);
        send_frame(16'b0000, 4);
        expect_now("poly0011", 4'b0011, 1'b0);
        tick();

        bus.poly = 4'b1001;
        tick();
        send_frame(16'b1_0000, 5);
        expect_now("poly1001", 4'b1001, 1'b0);
        tick();
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.data_in = 1'($urandom_range(0, 1));
            bus.chk_en  = 1'($urandom_range(0, 1));
            tick();
            expect_now("idle_ignore", 4'b1001, 1'b0);
        end
        bus.chk_en = 1'b0;

        send_frame(16'b1, 1);
        expect_now("one_bit", 4'b0001, 1'b0);
        tick();

        // Reset mid-frame, then the next enabled bit opens a fresh frame.
        bus.poly = 4'b0011;
        send_frame(16'b111, 3);
        expect_now("pre_reset", 4'b0111, 1'b0);
        rst_n       = 1'b1;
        bus.ctrl_en = 1'b1;
        bus.data_in = 1'b1;
        tick();
        expect_now("mid_reset", 4'b0000, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_now("post_reset_start", 4'b0001, 1'b0);
        bus.ctrl_en = 1'b0;
        tick();
        tick();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
